mac_rx_frameparse: RTL and testbench

- Receive-side counterpart of the MAC TX frame generator.
- Consumes 64-bit XGMII (8 lanes) from the PCS/RX side, validates the 8-byte start/preamble/SFD header, strips it, and delivers payload beats with per-byte keep, SOF/EOF and error flags to the MAC RX buffer.
- Detects terminate position, mid-frame control/error symbols and oversize frames.

---
 rtl/mac_rx_frameparse.sv | 219 +++++++++++++++++++++
 tb/tb_mac_rx_frameparse.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_frameparse.sv
// XGMII receive frame parser: validates the lane-0 start/preamble/SFD header, strips it and
// emits payload beats with keep/SOF/EOF/error flags through a one-beat hold register.
module mac_rx_frameparse #(
  parameter int N_CHANNELS      = 8,
  parameter int W_BYTE          = 8,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int W_LEN           = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clk_en,
  input  logic [N_CHANNELS-1:0]        i_xgmii_ctrl,
  input  logic [N_CHANNELS*W_BYTE-1:0] i_xgmii_data,
  output logic                         o_valid,
  output logic [N_CHANNELS-1:0]        o_keep,
  output logic [N_CHANNELS*W_BYTE-1:0] o_data,
  output logic                         o_sof,
  output logic                         o_eof,
  output logic                         o_err,
  output logic [W_LEN-1:0]             o_frame_len,
  output logic                         o_hdr_err
);

  localparam int W_DATA = N_CHANNELS * W_BYTE;
  localparam int W_LANE = $clog2(N_CHANNELS);

  localparam logic [W_BYTE-1:0] SYM_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] SYM_PREAM = W_BYTE'(8'h55);
  localparam logic [W_BYTE-1:0] SYM_SFD   = W_BYTE'(8'hD5);
  localparam logic [W_BYTE-1:0] SYM_TERM  = W_BYTE'(8'hFD);

  localparam logic [W_LEN:0]   MAX_SUM = (W_LEN+1)'(MAX_FRAME_BYTES);
  localparam logic [W_LEN-1:0] MAX_LEN = W_LEN'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP} state_t;

  state_t              state, state_n;
  logic [W_DATA-1:0]   hold_data, hold_data_n;
  logic [N_CHANNELS-1:0] hold_keep, hold_keep_n;
  logic                hold_valid, hold_valid_n;
  logic                hold_last, hold_last_n;
  logic                hold_sof, hold_sof_n;
  logic                first, first_n;
  logic [W_LEN-1:0]    count, count_n;

  logic                emit, emit_sof, emit_eof, emit_err, hdr_err_n;
  logic [W_DATA-1:0]   emit_data;
  logic [N_CHANNELS-1:0] emit_keep;
  logic [W_LEN-1:0]    emit_len;

  // Beat decode: first control lane, its symbol, header shape and byte count.
  logic                has_ctrl, term_any, hdr_start, hdr_ok, oversize;
  logic [W_LANE-1:0]   k;
  logic [W_BYTE-1:0]   sym_k;
  logic [N_CHANNELS-1:0] keep_beat;
  logic [W_DATA-1:0]   data_beat;
  logic [W_LEN:0]      sum;

  always_comb begin
    has_ctrl = |i_xgmii_ctrl;
    k        = '0;
    term_any = 1'b0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (i_xgmii_ctrl[i]) k = W_LANE'(i);
      if (i_xgmii_ctrl[i] && i_xgmii_data[i*W_BYTE +: W_BYTE] == SYM_TERM) term_any = 1'b1;
    end
    sym_k = i_xgmii_data[k*W_BYTE +: W_BYTE];

    hdr_start = i_xgmii_ctrl[0] && (i_xgmii_data[W_BYTE-1:0] == SYM_START);
    hdr_ok    = hdr_start && (i_xgmii_ctrl == N_CHANNELS'(1)) &&
                (i_xgmii_data[W_DATA-1 -: W_BYTE] == SYM_SFD);
    for (int i = 1; i < N_CHANNELS - 1; i++) begin
      if (i_xgmii_data[i*W_BYTE +: W_BYTE] != SYM_PREAM) hdr_ok = 1'b0;
    end

    for (int i = 0; i < N_CHANNELS; i++) begin
      keep_beat[i] = !has_ctrl || (i < int'(k));
      data_beat[i*W_BYTE +: W_BYTE] = keep_beat[i] ? i_xgmii_data[i*W_BYTE +: W_BYTE] : '0;
    end

    sum      = {1'b0, count} + (W_LEN+1)'(has_ctrl ? int'(k) : N_CHANNELS);
    oversize = sum > MAX_SUM;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    logic abort;
    state_n      = state;
    hold_data_n  = hold_data;
    hold_keep_n  = hold_keep;
    hold_valid_n = hold_valid;
    hold_last_n  = hold_last;
    hold_sof_n   = hold_sof;
    first_n      = first;
    count_n      = count;
    emit         = 1'b0;
    emit_data    = hold_data;
    emit_keep    = hold_keep;
    emit_sof     = hold_sof;
    emit_eof     = 1'b0;
    emit_err     = 1'b0;
    emit_len     = count;
    hdr_err_n    = 1'b0;
    abort        = 1'b0;

    // A tail beat parked after TERM leaves on the very next edge, enabled or not.
    if (hold_valid && hold_last) begin
      emit         = 1'b1;
      emit_eof     = 1'b1;
      hold_valid_n = 1'b0;
      hold_last_n  = 1'b0;
    end

    if (i_clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (hdr_ok) begin
            state_n = S_DATA;
            count_n = '0;
            first_n = 1'b1;
          end else if (hdr_start) begin
            hdr_err_n = 1'b1;
            state_n   = S_DROP;
          end
        end
        S_DATA: begin
          if (has_ctrl && sym_k != SYM_TERM) begin
            abort   = 1'b1;
            state_n = S_DROP;
          end else if (oversize) begin
            abort    = 1'b1;
            emit_len = MAX_LEN;
            state_n  = term_any ? S_IDLE : S_DROP;
          end else if (has_ctrl && k == '0) begin
            emit         = hold_valid;
            emit_eof     = 1'b1;
            hold_valid_n = 1'b0;
            state_n      = S_IDLE;
          end else begin
            emit         = hold_valid;
            hold_data_n  = data_beat;
            hold_keep_n  = keep_beat;
            hold_valid_n = 1'b1;
            hold_last_n  = has_ctrl;
            hold_sof_n   = first;
            first_n      = 1'b0;
            count_n      = sum[W_LEN-1:0];
            if (has_ctrl) state_n = S_IDLE;
          end
          if (abort) begin
            emit         = 1'b1;
            emit_eof     = 1'b1;
            emit_err     = 1'b1;
            hold_valid_n = 1'b0;
            first_n      = 1'b0;
            if (!hold_valid) begin
              emit_data = '0;
              emit_keep = '0;
              emit_sof  = first;
            end
          end
        end
        S_DROP: begin
          if (term_any || &i_xgmii_ctrl) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_sof   <= 1'b0;
      first      <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_n;
      hold_data  <= hold_data_n;
      hold_keep  <= hold_keep_n;
      hold_valid <= hold_valid_n;
      hold_last  <= hold_last_n;
      hold_sof   <= hold_sof_n;
      first      <= first_n;
      count      <= count_n;
    end
  end

  // Data/keep/len only change on an emitted beat; flags are pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid     <= 1'b0;
      o_keep      <= '0;
      o_data      <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_err       <= 1'b0;
      o_frame_len <= '0;
      o_hdr_err   <= 1'b0;
    end else begin
      o_valid   <= emit;
      o_sof     <= emit && emit_sof;
      o_eof     <= emit && emit_eof;
      o_err     <= emit && emit_err;
      o_hdr_err <= hdr_err_n;
      if (emit) begin
        o_data      <= emit_data;
        o_keep      <= emit_keep;
        o_frame_len <= emit_eof ? emit_len : '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_frameparse.sv
// Directed bench for mac_rx_frameparse (built with MAX_FRAME_BYTES=64); emitted beats are
// logged by a monitor and compared per scenario against hand-computed expectations.
module tb_mac_rx_frameparse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [7:0]  ctrl;
  logic [63:0] data;
  logic        o_valid, o_sof, o_eof, o_err, o_hdr_err;
  logic [7:0]  o_keep;
  logic [63:0] o_data;
  logic [15:0] o_frame_len;

  mac_rx_frameparse #(
    .N_CHANNELS(8), .W_BYTE(8), .MAX_FRAME_BYTES(64), .W_LEN(16)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(clk_en),
    .i_xgmii_ctrl(ctrl), .i_xgmii_data(data),
    .o_valid(o_valid), .o_keep(o_keep), .o_data(o_data),
    .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err),
    .o_frame_len(o_frame_len), .o_hdr_err(o_hdr_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] HDR = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] IDL = 64'h0707_0707_0707_0707;
  localparam logic [63:0] T0  = 64'h0707_0707_0707_07FD;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        s, e, r;
    logic [15:0] len;
  } beat_t;

  beat_t q[$];
  beat_t exp_q[$];
  int    qcyc[$];
  int    cyc = 0;
  int    last_cyc;
  int    hdr_cnt;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        q.push_back({o_data, o_keep, o_sof, o_eof, o_err, (o_eof ? o_frame_len : 16'd0)});
        qcyc.push_back(cyc);
      end
      if (o_hdr_err) hdr_cnt++;
    end
  end

  function automatic logic [63:0] mk(input logic [7:0] b);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = b + 8'(i);
    return d;
  endfunction

  function automatic beat_t bt(input logic [63:0] d, input logic [7:0] k,
                               input logic s, input logic e, input logic r, input logic [15:0] len);
    return {d, k, s, e, r, len};
  endfunction

  task automatic drive(input logic [7:0] c, input logic [63:0] d, input logic en = 1'b1);
    @(negedge clk);
    clk_en   = en;
    ctrl     = c;
    data     = d;
    last_cyc = cyc + 1;
  endtask

  task automatic flush(input int n);
    repeat (n) drive(8'hFF, IDL);
    @(negedge clk);
    #1;
  endtask

  task automatic start_test();
    q.delete();
    qcyc.delete();
    exp_q.delete();
    hdr_cnt = 0;
  endtask

  task automatic compare_beats(input string name);
    n_checks++;
    if (q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s beat count: got %0d want %0d", name, q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s beat%0d: got %h want %h", name, i,
                 (i < q.size()) ? q[i] : beat_t'(0), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({o_valid, o_keep, o_data, o_sof, o_eof, o_err, o_frame_len, o_hdr_err} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got v=%b k=%h d=%h s=%b e=%b r=%b len=%0d h=%b want all 0",
               o_valid, o_keep, o_data, o_sof, o_eof, o_err, o_frame_len, o_hdr_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_test();
    flush(3);
    n_checks++;
    if (q.size() != 0 || hdr_cnt != 0) begin
      n_fail++;
      $display("FAIL reset idle stream: got %0d beats %0d hdr_err want 0 0", q.size(), hdr_cnt);
    end
  endtask

  task automatic test_basic();
    int t0;
    start_test();
    drive(8'hFF, IDL);
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h00));
    t0 = last_cyc;
    drive(8'h00, mk(8'h08));
    drive(8'h00, mk(8'h10));
    drive(8'hFF, T0);
    flush(3);
    exp_q.push_back(bt(mk(8'h00), 8'hFF, 1, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h08), 8'hFF, 0, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h10), 8'hFF, 0, 1, 0, 16'd24));
    compare_beats("basic");
    n_checks++;
    if (qcyc.size() == 0 || qcyc[0] != t0 + 1) begin
      n_fail++;
      $display("FAIL basic latency: got edge %0d want %0d",
               (qcyc.size() != 0) ? qcyc[0] : -1, t0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h00));
    drive(8'hE0, 64'h0707_FD0C_0B0A_0908);
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h20));
    drive(8'hFF, T0);
    flush(3);
    exp_q.push_back(bt(mk(8'h00), 8'hFF, 1, 0, 0, 0));
    exp_q.push_back(bt(64'h0000_000C_0B0A_0908, 8'h1F, 0, 1, 0, 16'd13));
    exp_q.push_back(bt(mk(8'h20), 8'hFF, 1, 1, 0, 16'd8));
    compare_beats("back_to_back");
  endtask

  task automatic test_hdr_err();
    start_test();
    drive(8'h10, 64'h5555_55FB_0707_0707);
    drive(8'hFF, IDL);
    drive(8'h01, 64'hD555_5555_5455_55FB);
    drive(8'h00, mk(8'h00));
    drive(8'h00, mk(8'h08));
    drive(8'hFF, T0);
    flush(2);
    n_checks++;
    if (hdr_cnt != 1) begin
      n_fail++;
      $display("FAIL hdr_err pulses: got %0d want 1", hdr_cnt);
    end
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h40));
    drive(8'hFF, T0);
    flush(3);
    exp_q.push_back(bt(mk(8'h40), 8'hFF, 1, 1, 0, 16'd8));
    compare_beats("hdr_err");
  endtask

  task automatic test_mid_err();
    start_test();
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h00));
    drive(8'h00, mk(8'h08));
    drive(8'h04, 64'h0707_0707_07FE_1110);
    drive(8'h00, mk(8'h18));
    drive(8'hF0, 64'h0707_07FD_1312_1110);
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h50));
    drive(8'hFF, T0);
    drive(8'h01, HDR);
    drive(8'h01, 64'h0707_0707_0707_07FE);
    drive(8'h00, mk(8'h60));
    flush(3);
    exp_q.push_back(bt(mk(8'h00), 8'hFF, 1, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h08), 8'hFF, 0, 1, 1, 16'd16));
    exp_q.push_back(bt(mk(8'h50), 8'hFF, 1, 1, 0, 16'd8));
    exp_q.push_back(bt(64'h0, 8'h00, 1, 1, 1, 16'd0));
    compare_beats("mid_err");
  endtask

  task automatic test_oversize();
    start_test();
    drive(8'h01, HDR);
    for (int i = 0; i < 10; i++) drive(8'h00, mk(8'(i * 8)));
    drive(8'hFF, T0);
    flush(3);
    exp_q.push_back(bt(mk(8'h00), 8'hFF, 1, 0, 0, 0));
    for (int i = 1; i < 7; i++) exp_q.push_back(bt(mk(8'(i * 8)), 8'hFF, 0, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h38), 8'hFF, 0, 1, 1, 16'd64));
    compare_beats("oversize");
  endtask

  task automatic test_clk_en();
    int c1, c2, c3, c4;
    start_test();
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h00));
    drive(8'h00, mk(8'hA0), 1'b0);
    drive(8'h00, mk(8'h08));
    c1 = last_cyc;
    drive(8'h00, mk(8'hA8), 1'b0);
    drive(8'hFF, T0, 1'b0);
    drive(8'h00, mk(8'h10));
    c2 = last_cyc;
    drive(8'h04, 64'h0707_0707_07FE_0000, 1'b0);
    drive(8'hF8, 64'h0707_0707_FD1A_1918);
    c3 = last_cyc;
    drive(8'h00, mk(8'hB0), 1'b0);
    c4 = last_cyc;
    flush(3);
    exp_q.push_back(bt(mk(8'h00), 8'hFF, 1, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h08), 8'hFF, 0, 0, 0, 0));
    exp_q.push_back(bt(mk(8'h10), 8'hFF, 0, 0, 0, 0));
    exp_q.push_back(bt(64'h0000_0000_001A_1918, 8'h07, 0, 1, 0, 16'd27));
    compare_beats("clk_en");
    n_checks++;
    if (qcyc.size() != 4 || qcyc[0] != c1 || qcyc[1] != c2 || qcyc[2] != c3 || qcyc[3] != c4) begin
      n_fail++;
      $display("FAIL clk_en timing: got %p want '{%0d, %0d, %0d, %0d}", qcyc, c1, c2, c3, c4);
    end
  endtask

  task automatic test_async_reset();
    start_test();
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h00));
    drive(8'h00, mk(8'h08));
    drive(8'h00, mk(8'h10));
    @(posedge clk);
    #2;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== mk(8'h08)) begin
      n_fail++;
      $display("FAIL pre_reset beat: got v=%b d=%h want v=1 d=%h", o_valid, o_data, mk(8'h08));
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_keep, o_data, o_sof, o_eof, o_err, o_frame_len} !== '0) begin
      n_fail++;
      $display("FAIL async_reset outputs: got v=%b k=%h d=%h want all 0", o_valid, o_keep, o_data);
    end
    @(negedge clk);
    ctrl  = 8'hFF;
    data  = IDL;
    rst_n = 1'b1;
    q.delete();
    qcyc.delete();
    drive(8'h00, mk(8'h18));
    drive(8'hFF, T0);
    flush(3);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL after_reset no eof: got %0d beats want 0", q.size());
    end
    drive(8'h01, HDR);
    drive(8'h00, mk(8'h70));
    drive(8'hFF, T0);
    flush(3);
    exp_q.push_back(bt(mk(8'h70), 8'hFF, 1, 1, 0, 16'd8));
    compare_beats("after_reset");
  endtask

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b1;
    ctrl   = 8'hFF;
    data   = IDL;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_hdr_err();
    test_mid_err();
    test_oversize();
    test_clk_en();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
